// File: rtl/io_seq_checker_if.sv
// Stream bundle between the GLIP host FIFOs and io_seq_checker.
// The master side drives host->logic words and report requests; the slave side is the checker.
interface io_seq_checker_if #(
    parameter int WIDTH = 16
) ();
    logic             fifo_in_valid;
    logic [WIDTH-1:0] fifo_in_data;
    logic             fifo_in_ready;
    logic             fifo_out_valid;
    logic [WIDTH-1:0] fifo_out_data;
    logic             fifo_out_ready;
    logic             report_req;
    logic             error;
    logic             idle;

    modport master (
        output fifo_in_valid, fifo_in_data, fifo_out_ready, report_req,
        input  fifo_in_ready, fifo_out_valid, fifo_out_data, error, idle
    );

    modport slave (
        input  fifo_in_valid, fifo_in_data, fifo_out_ready, report_req,
        output fifo_in_ready, fifo_out_valid, fifo_out_data, error, idle
    );
endinterface

// File: rtl/io_seq_checker.sv
// Incrementing-sequence checker with a 3-word status report (header, word count, error count).
// Optional IO_SEQ_CHECKER_BACKPRESSURE_EN adds LFSR-driven input stalls (~25%).
//
// state  | meaning
// IDLE   | no word seen since reset; first word seeds the expected value
// CHECK  | comparing each accepted word against the expected value
// REPORT | sending header / word count / error count upstream
module io_seq_checker #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 32
) (
    input logic              clk,
    input logic              rst,
    io_seq_checker_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    localparam logic [WIDTH-1:0]     HEADER  = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0]           state;
    logic [1:0]           ret_state;
    logic [1:0]           rpt_idx;
    logic [WIDTH-1:0]     expected;
    logic [CNT_WIDTH-1:0] word_cnt;
    logic [CNT_WIDTH-1:0] err_cnt;
    logic [CNT_WIDTH-1:0] word_cnt_next;
    logic [CNT_WIDTH-1:0] err_cnt_next;
    logic [WIDTH-1:0]     snap_words;
    logic [WIDTH-1:0]     snap_errs;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 error_q;
    logic                 stall;
    logic                 in_ready;
    logic                 accept;
    logic                 mismatch;

`ifdef IO_SEQ_CHECKER_BACKPRESSURE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = (lfsr[1:0] == 2'b11);
`else
    assign stall = 1'b0;
`endif

    // ready is gated by rst directly so it reads 0 for the whole reset window
    assign in_ready = rst && ((state == ST_IDLE) || (state == ST_CHECK)) && !stall;
    assign accept   = bus.fifo_in_valid && in_ready;
    assign mismatch = accept && (state == ST_CHECK) && (bus.fifo_in_data != expected);

    always_comb begin
        word_cnt_next = word_cnt;
        err_cnt_next  = err_cnt;
        if (accept) begin
            if (state == ST_IDLE) begin
                word_cnt_next = CNT_WIDTH'(1);
            end else if (word_cnt != CNT_MAX) begin
                word_cnt_next = word_cnt + CNT_WIDTH'(1);
            end
        end
        if (mismatch && (err_cnt != CNT_MAX)) begin
            err_cnt_next = err_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            ret_state  <= ST_IDLE;
            rpt_idx    <= 2'd0;
            expected   <= '0;
            word_cnt   <= '0;
            err_cnt    <= '0;
            snap_words <= '0;
            snap_errs  <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_CHECK: begin
                    word_cnt <= word_cnt_next;
                    err_cnt  <= err_cnt_next;
                    if (accept) begin
                        expected <= bus.fifo_in_data + WIDTH'(1);
                    end
                    if (mismatch) begin
                        error_q <= 1'b1;
                    end
                    // snapshot takes the post-update counters so a same-cycle word is included
                    if (bus.report_req) begin
                        state      <= ST_REPORT;
                        ret_state  <= ((state == ST_CHECK) || accept) ? ST_CHECK : ST_IDLE;
                        rpt_idx    <= 2'd0;
                        out_valid  <= 1'b1;
                        out_data   <= HEADER;
                        snap_words <= word_cnt_next[WIDTH-1:0];
                        snap_errs  <= err_cnt_next[WIDTH-1:0];
                    end else if (accept) begin
                        state <= ST_CHECK;
                    end
                end
                ST_REPORT: begin
                    if (out_valid && bus.fifo_out_ready) begin
                        case (rpt_idx)
                            2'd0: begin
                                out_data <= snap_words;
                                rpt_idx  <= 2'd1;
                            end
                            2'd1: begin
                                out_data <= snap_errs;
                                rpt_idx  <= 2'd2;
                            end
                            default: begin
                                out_data  <= '0;
                                out_valid <= 1'b0;
                                rpt_idx   <= 2'd0;
                                state     <= ret_state;
                            end
                        endcase
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.fifo_in_ready  = in_ready;
    assign bus.fifo_out_valid = out_valid;
    assign bus.fifo_out_data  = out_data;
    assign bus.error          = error_q;
    assign bus.idle           = (state == ST_IDLE);
endmodule

// File: tb/tb_io_seq_checker.sv
// Directed bench for io_seq_checker: cycle-accurate vector table plus handshake-level sequences.
module tb_io_seq_checker;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    io_seq_checker_if #(.WIDTH(WIDTH)) bus ();

    io_seq_checker #(.WIDTH(WIDTH), .CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int stalls = 0;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [15:0] din;
        logic        ordy;
        logic        req;
        logic        e_rdy;
        logic        e_ov;
        logic [15:0] e_od;
        logic        e_err;
        logic        e_idle;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic v(input logic r, input logic vl, input logic [15:0] d, input logic o, input logic q,
                     input logic er, input logic eo, input logic [15:0] ed, input logic ee, input logic ei);
        vec_t t;
        t = '{r, vl, d, o, q, er, eo, ed, ee, ei};
        tbl.push_back(t);
    endtask

    task automatic drive_idle();
        @(negedge clk);
        bus.fifo_in_valid  = 1'b0;
        bus.fifo_in_data   = '0;
        bus.fifo_out_ready = 1'b0;
        bus.report_req     = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset idle", {31'd0, bus.idle}, 32'd1);
        check("reset error", {31'd0, bus.error}, 32'd0);
        check("reset out_valid", {31'd0, bus.fifo_out_valid}, 32'd0);
        check("reset in_ready", {31'd0, bus.fifo_in_ready}, 32'd0);
        rst = 1'b1;
    endtask

    task automatic send_word(input logic [15:0] d);
        int n;
        @(negedge clk);
        bus.fifo_in_valid = 1'b1;
        bus.fifo_in_data  = d;
        #1;
        n = 0;
        while (!bus.fifo_in_ready && n < 50) begin
            stalls++;
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.fifo_in_ready) check("send timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic request_report();
        @(negedge clk);
        bus.fifo_in_valid = 1'b0;
        bus.report_req    = 1'b1;
        @(posedge clk);
        #1;
        bus.report_req = 1'b0;
    endtask

    task automatic recv(input logic [15:0] exp, input int stall_cycles, input string name);
        bus.fifo_out_ready = 1'b0;
        for (int k = 0; k < stall_cycles; k++) begin
            @(negedge clk);
            #1;
            check({name, " held valid"}, {31'd0, bus.fifo_out_valid}, 32'd1);
            check({name, " held data"}, {16'd0, bus.fifo_out_data}, {16'd0, exp});
            check({name, " in_ready low"}, {31'd0, bus.fifo_in_ready}, 32'd0);
        end
        @(negedge clk);
        bus.fifo_out_ready = 1'b1;
        #1;
        check({name, " valid"}, {31'd0, bus.fifo_out_valid}, 32'd1);
        check({name, " data"}, {16'd0, bus.fifo_out_data}, {16'd0, exp});
        @(posedge clk);
        #1;
        bus.fifo_out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // rst vld din ordy req | rdy ov od err idle
        v(0,0,16'h0000,0,0, 0,0,16'h0000,0,1);
        v(1,1,16'h0001,0,0, 1,0,16'h0000,0,1);
        v(1,1,16'h0002,0,0, 1,0,16'h0000,0,0);
        v(1,1,16'h0003,0,0, 1,0,16'h0000,0,0);
        v(1,1,16'h0007,0,0, 1,0,16'h0000,0,0);
        v(1,1,16'h0008,0,0, 1,0,16'h0000,1,0);
        v(1,1,16'h0009,0,0, 1,0,16'h0000,1,0);
        v(1,0,16'h0000,0,1, 1,0,16'h0000,1,0);
        v(1,0,16'h0000,1,0, 0,1,16'hFFFE,1,0);
        v(1,0,16'h0000,1,0, 0,1,16'h0006,1,0);
        v(1,0,16'h0000,1,0, 0,1,16'h0001,1,0);
        v(1,0,16'h0000,0,0, 1,0,16'h0000,1,0);
        v(0,0,16'h0000,0,0, 0,0,16'h0000,1,0);
        v(0,0,16'h0000,0,0, 0,0,16'h0000,0,1);
        v(1,1,16'hFFFE,0,0, 1,0,16'h0000,0,1);
        v(1,1,16'hFFFF,0,0, 1,0,16'h0000,0,0);
        v(1,1,16'h0000,0,0, 1,0,16'h0000,0,0);
        v(1,1,16'h0001,0,1, 1,0,16'h0000,0,0);
        v(1,0,16'h0000,1,0, 0,1,16'hFFFE,0,0);
        v(1,0,16'h0000,1,0, 0,1,16'h0004,0,0);
        v(1,0,16'h0000,1,0, 0,1,16'h0000,0,0);
        v(1,0,16'h0000,0,0, 1,0,16'h0000,0,0);
        v(0,0,16'h0000,0,0, 0,0,16'h0000,0,0);
        v(1,0,16'h0000,0,1, 1,0,16'h0000,0,1);
        v(1,0,16'h0000,1,0, 0,1,16'hFFFE,0,0);
        v(1,0,16'h0000,1,0, 0,1,16'h0000,0,0);
        v(1,0,16'h0000,1,0, 0,1,16'h0000,0,0);
        v(1,0,16'h0000,0,0, 1,0,16'h0000,0,1);

        rst                = 1'b0;
        bus.fifo_in_valid  = 1'b0;
        bus.fifo_in_data   = '0;
        bus.fifo_out_ready = 1'b0;
        bus.report_req     = 1'b0;
        @(posedge clk);
        @(posedge clk);

`ifndef IO_SEQ_CHECKER_BACKPRESSURE_EN
        // exact per-cycle readiness only holds without random stalls
        foreach (tbl[i]) begin
            @(negedge clk);
            rst                = tbl[i].rst;
            bus.fifo_in_valid  = tbl[i].vld;
            bus.fifo_in_data   = tbl[i].din;
            bus.fifo_out_ready = tbl[i].ordy;
            bus.report_req     = tbl[i].req;
            #1;
            check($sformatf("vec%0d in_ready", i), {31'd0, bus.fifo_in_ready}, {31'd0, tbl[i].e_rdy});
            check($sformatf("vec%0d out_valid", i), {31'd0, bus.fifo_out_valid}, {31'd0, tbl[i].e_ov});
            check($sformatf("vec%0d out_data", i), {16'd0, bus.fifo_out_data}, {16'd0, tbl[i].e_od});
            check($sformatf("vec%0d error", i), {31'd0, bus.error}, {31'd0, tbl[i].e_err});
            check($sformatf("vec%0d idle", i), {31'd0, bus.idle}, {31'd0, tbl[i].e_idle});
        end
`endif

        // 256-word clean run
        do_reset();
        for (int w = 5; w <= 16'h0104; w++) send_word(16'(w));
        drive_idle();
        request_report();
        recv(16'hFFFE, 0, "s1 R0");
        recv(16'h0100, 0, "s1 R1");
        recv(16'h0000, 0, "s1 R2");
        #1;
        check("s1 error", {31'd0, bus.error}, 32'd0);

        // stalled report with a second request while reporting
        request_report();
        @(negedge clk);
        bus.report_req = 1'b1;
        #1;
        check("s4 extra req in_ready", {31'd0, bus.fifo_in_ready}, 32'd0);
        @(posedge clk);
        #1;
        bus.report_req = 1'b0;
        recv(16'hFFFE, 5, "s4 R0");
        recv(16'h0100, 5, "s4 R1");
        recv(16'h0000, 5, "s4 R2");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("s4 no requeued report", {31'd0, bus.fifo_out_valid}, 32'd0);
            check("s4 back in check", {31'd0, bus.idle}, 32'd0);
        end

        // reset in the middle of a report
        do_reset();
        send_word(16'h0001);
        send_word(16'h0002);
        send_word(16'h0005);
        drive_idle();
        #1;
        check("s6 error set", {31'd0, bus.error}, 32'd1);
        request_report();
        recv(16'hFFFE, 0, "s6 R0");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("s6 R1 presented", {16'd0, bus.fifo_out_data}, 32'h0003);
        check("s6 in_ready in reset", {31'd0, bus.fifo_in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("s6 out_valid cleared", {31'd0, bus.fifo_out_valid}, 32'd0);
        check("s6 error cleared", {31'd0, bus.error}, 32'd0);
        check("s6 idle", {31'd0, bus.idle}, 32'd1);
        rst = 1'b1;

`ifdef IO_SEQ_CHECKER_BACKPRESSURE_EN
        do_reset();
        stalls = 0;
        for (int w = 0; w < 1000; w++) send_word(16'(w));
        drive_idle();
        request_report();
        recv(16'hFFFE, 0, "bp R0");
        recv(16'h03E8, 0, "bp R1");
        recv(16'h0000, 0, "bp R2");
        check("bp stalls observed", {31'd0, (stalls != 0)}, 32'd1);
`endif

        drive_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
